// File: rtl/testenc_mux_pipe.sv
// Pipelined N:1 select mux with valid/ready flow control: a binary mux tree with a register
// bank every REG_EVERY levels. Out-of-range selects produce zero data and a per-beat error flag.
module testenc_mux_pipe #(
    parameter int NUM_INPUTS = 14,
    parameter int DATA_WIDTH = 128,
    parameter int SEL_WIDTH  = 4,
    parameter int REG_EVERY  = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             sel_err,
    output logic [15:0]                      err_cnt
);

    localparam int L   = (NUM_INPUTS <= 2) ? 1 : $clog2(NUM_INPUTS);
    localparam int LAT = (L + REG_EVERY - 1) / REG_EVERY;
    localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH + 1)'(NUM_INPUTS);

    logic [LAT-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [LAT-1:0][SEL_WIDTH-1:0]                  sel_q, sel_d;
    logic [LAT-1:0]                                 err_q, err_d;
    logic [LAT-1:0]                                 v_q, v_d;
    logic [LAT-1:0]                                 load, adv;
    logic [15:0]                                    err_cnt_q, err_cnt_d;

    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] cur_n, nxt_n;
    logic [SEL_WIDTH-1:0]                  cur_sel;
    logic                                  cur_err;
    int                                    cnt, stg;

    // Ready ripples back from the output stage; an empty stage always loads.
    always_comb begin
        adv  = '0;
        load = '0;
        adv[LAT-1] = v_q[LAT-1] & dout_ready;
        for (int s = LAT - 1; s >= 1; s--) begin
            load[s]  = !v_q[s] || adv[s];
            adv[s-1] = v_q[s-1] & load[s];
        end
        load[0] = !v_q[0] || adv[0];
    end

    always_comb begin
        v_d    = v_q;
        v_d[0] = load[0] ? in_valid : v_q[0];
        for (int s = 1; s < LAT; s++) begin
            v_d[s] = load[s] ? v_q[s-1] : v_q[s];
        end
    end

    // Walk the tree level by level; at registered levels capture into the bank and
    // continue the walk from the registered copy.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        cur_n   = din;
        nxt_n   = '0;
        cur_sel = sel;
        cur_err = ({1'b0, sel} >= NUM_SEL);
        cnt     = NUM_INPUTS;
        stg     = 0;
        for (int k = 1; k <= L; k++) begin
            nxt_n = '0;
            for (int j = 0; j < (NUM_INPUTS + 1) / 2; j++) begin
                if (2 * j + 1 < cnt) begin
                    nxt_n[j] = cur_sel[k-1]
                        ? cur_n[(2 * j + 1 < NUM_INPUTS) ? 2 * j + 1 : 2 * j]
                        : cur_n[2 * j];
                end else if (2 * j < cnt) begin
                    nxt_n[j] = cur_n[2 * j];
                end
            end
            cnt = (cnt + 1) / 2;
            if ((k % REG_EVERY == 0) || (k == L)) begin
                if (load[stg]) begin
                    data_d[stg] = (k == L && cur_err) ? '0 : nxt_n;
                    sel_d[stg]  = cur_sel;
                    err_d[stg]  = cur_err;
                end
                cur_n   = data_q[stg];
                cur_sel = sel_q[stg];
                cur_err = err_q[stg];
                stg     = stg + 1;
            end else begin
                cur_n = nxt_n;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (dout_valid && dout_ready && sel_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            data_q    <= '0;
            sel_q     <= '0;
            err_q     <= '0;
            v_q       <= '0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            v_q       <= v_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready   = load[0] & ~ap_rst;
    assign dout       = data_q[LAT-1][0];
    assign dout_valid = v_q[LAT-1];
    assign sel_err    = v_q[LAT-1] & err_q[LAT-1];
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_testenc_mux_pipe.sv
// Scoreboard bench for testenc_mux_pipe: a default 14:1x128 instance and a 5:1x8 instance
// with a register after every level.
module tb_testenc_mux_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ap_rst;

    logic [14*128-1:0] din_a;
    logic [3:0]        sel_a;
    logic              in_valid_a, in_ready_a;
    logic [127:0]      dout_a;
    logic              dout_valid_a, dout_ready_a, sel_err_a;
    logic [15:0]       err_cnt_a;

    logic [5*8-1:0]    din_b;
    logic [2:0]        sel_b;
    logic              in_valid_b, in_ready_b;
    logic [7:0]        dout_b;
    logic              dout_valid_b, dout_ready_b, sel_err_b;
    logic [15:0]       err_cnt_b;

    testenc_mux_pipe u_dut_a (
        .ap_clk(clk), .ap_rst(ap_rst), .din(din_a), .sel(sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .dout(dout_a),
        .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
        .sel_err(sel_err_a), .err_cnt(err_cnt_a)
    );

    testenc_mux_pipe #(.NUM_INPUTS(5), .DATA_WIDTH(8), .SEL_WIDTH(3), .REG_EVERY(1)) u_dut_b (
        .ap_clk(clk), .ap_rst(ap_rst), .din(din_b), .sel(sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .dout(dout_b),
        .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
        .sel_err(sel_err_b), .err_cnt(err_cnt_b)
    );

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!ap_rst && dout_valid_a && dout_ready_a) begin
            if (sb_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_beat: got dout=%h with no beat outstanding, expected none", dout_a);
            end else begin
                ea = sb_a.pop_front();
                chk("a_dout", dout_a, ea.data);
                chk("a_sel_err", 128'(sel_err_a), 128'(ea.err));
                if (ea.lat) chk("a_latency", 128'(cyc - ea.acc), 128'(2));
            end
        end
    end

    always @(negedge clk) begin
        if (!ap_rst && dout_valid_b && dout_ready_b) begin
            if (sb_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_beat: got dout=%h with no beat outstanding, expected none", dout_b);
            end else begin
                eb = sb_b.pop_front();
                chk("b_dout", 128'(dout_b), eb.data);
                chk("b_sel_err", 128'(sel_err_b), 128'(eb.err));
                if (eb.lat) chk("b_latency", 128'(cyc - eb.acc), 128'(3));
            end
        end
    end

    // Drivers are entered and left one time unit after a rising edge.
    task automatic send_a(input logic [3:0] s, input bit lat);
        exp_t x;
        logic [7:0] bb;
        bb = {4'h0, s};
        x.data = (s < 4'd14) ? {16{bb}} : '0;
        x.err  = (s >= 4'd14);
        x.lat  = lat;
        x.acc  = 0;
        in_valid_a = 1'b1;
        sel_a      = s;
        for (int budget = 0; budget < 50; budget++) begin
            @(negedge clk);
            if (in_ready_a) begin
                x.acc = cyc;
                sb_a.push_back(x);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL a_send_timeout: sel=%0d in_ready stayed 0, expected 1", s);
    endtask

    task automatic send_b(input logic [2:0] s, input bit lat);
        exp_t x;
        x.data = (s < 3'd5) ? 128'(8'hA0 + {5'b0, s}) : '0;
        x.err  = (s >= 3'd5);
        x.lat  = lat;
        x.acc  = 0;
        in_valid_b = 1'b1;
        sel_b      = s;
        for (int budget = 0; budget < 50; budget++) begin
            @(negedge clk);
            if (in_ready_b) begin
                x.acc = cyc;
                sb_b.push_back(x);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL b_send_timeout: sel=%0d in_ready stayed 0, expected 1", s);
    endtask

    task automatic drain(input bit is_b);
        int n;
        n = 0;
        while (((is_b ? sb_b.size() : sb_a.size()) != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if ((is_b ? sb_b.size() : sb_a.size()) != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: dut_b=%0d beats outstanding=%0d, expected 0", is_b,
                     is_b ? sb_b.size() : sb_a.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 14; k++) din_a[k*128 +: 128] = {16{8'(k)}};
        for (int k = 0; k < 5; k++) din_b[k*8 +: 8] = 8'hA0 + 8'(k);
        ap_rst       = 1'b1;
        in_valid_a   = 1'b0;
        sel_a        = '0;
        dout_ready_a = 1'b1;
        in_valid_b   = 1'b0;
        sel_b        = '0;
        dout_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 ap_rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dout_valid", 128'(dout_valid_a), 128'(0));
        chk("rst_sel_err", 128'(sel_err_a), 128'(0));
        chk("rst_err_cnt", 128'(err_cnt_a), 128'(0));
        chk("rst_dout", dout_a, 128'(0));
        chk("rst_in_ready", 128'(in_ready_a), 128'(1));
        chk("rst_b_dout_valid", 128'(dout_valid_b), 128'(0));
        @(posedge clk); #1;

        // Full select sweep, back to back
        for (int s = 0; s < 14; s++) send_a(4'(s), 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);

        // Out-of-range selects
        send_a(4'd14, 1'b1);
        send_a(4'd15, 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);
        @(negedge clk);
        chk("err_cnt_two", 128'(err_cnt_a), 128'(2));
        @(posedge clk); #1;

        // Backpressure: consumer stalls for five cycles
        dout_ready_a = 1'b0;
        send_a(4'd3, 1'b0);
        send_a(4'd4, 1'b0);
        in_valid_a = 1'b1;
        sel_a      = 4'd5;
        @(negedge clk);
        chk("bp_in_ready_low", 128'(in_ready_a), 128'(0));
        chk("bp_dout_valid", 128'(dout_valid_a), 128'(1));
        chk("bp_dout_hold", dout_a, {16{8'h03}});
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_dout_hold", dout_a, {16{8'h03}});
            chk("bp_dout_valid", 128'(dout_valid_a), 128'(1));
        end
        @(posedge clk); #1;
        dout_ready_a = 1'b1;
        send_a(4'd5, 1'b0);
        in_valid_a = 1'b0;
        drain(1'b0);

        // Reset with two beats in flight; a beat offered during reset is dropped
        dout_ready_a = 1'b0;
        send_a(4'd1, 1'b0);
        send_a(4'd2, 1'b0);
        in_valid_a = 1'b1;
        sel_a      = 4'd9;
        ap_rst     = 1'b1;
        @(posedge clk); #1;
        ap_rst     = 1'b0;
        in_valid_a = 1'b0;
        sb_a.delete();
        @(negedge clk);
        chk("mid_rst_dout_valid", 128'(dout_valid_a), 128'(0));
        chk("mid_rst_err_cnt", 128'(err_cnt_a), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready_a), 128'(1));
        @(posedge clk); #1;
        dout_ready_a = 1'b1;
        send_a(4'd7, 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);

        // Five-input instance, three pipeline stages
        send_b(3'd4, 1'b1);
        send_b(3'd0, 1'b1);
        send_b(3'd3, 1'b1);
        send_b(3'd1, 1'b1);
        send_b(3'd5, 1'b1);
        send_b(3'd6, 1'b1);
        send_b(3'd7, 1'b1);
        send_b(3'd2, 1'b1);
        in_valid_b = 1'b0;
        drain(1'b1);
        @(negedge clk);
        chk("b_err_cnt", 128'(err_cnt_b), 128'(3));
        @(posedge clk); #1;

        // Error counter saturation over 65537 out-of-range beats
        for (int i = 0; i < 65534; i++) send_a((i % 2 == 0) ? 4'd14 : 4'd15, 1'b0);
        in_valid_a = 1'b0;
        drain(1'b0);
        @(negedge clk);
        chk("err_cnt_fffe", 128'(err_cnt_a), 128'(16'hFFFE));
        @(posedge clk); #1;
        send_a(4'd15, 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);
        @(negedge clk);
        chk("err_cnt_sat", 128'(err_cnt_a), 128'(16'hFFFF));
        @(posedge clk); #1;
        send_a(4'd14, 1'b1);
        send_a(4'd15, 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);
        @(negedge clk);
        chk("err_cnt_hold", 128'(err_cnt_a), 128'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
